// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if: operand-issue / result-writeback handshake bundle for fp_mul_seq
// in_valid/in_ready/a/b: operand side; out_valid/out_ready/q/flags: result side
// flags = {NV, DZ, UF, OF, NX}; master drives operands, slave is the multiplier
interface fp_mul_seq_if #(
    parameter int EB = 5,
    parameter int MB = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [EB+MB:0] a;
    logic [EB+MB:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [EB+MB:0] q;
    logic [4:0]    flags;

    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, q, flags);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, q, flags);
endinterface

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 multiplier (FTZ, RNE), shift-add significand datapath
// i_clk: clock, i_rst_n: async active-low reset
// bus (slave): in_valid/in_ready/a/b accept operands, out_valid/out_ready/q/flags return result
module fp_mul_seq #(
    parameter int EB = 5,
    parameter int MB = 10
) (
    input logic         i_clk,
    input logic         i_rst_n,
    fp_mul_seq_if.slave bus
);
    localparam int W    = 1 + EB + MB;
    localparam int P    = 2 * (MB + 1);
    localparam int E    = EB + 2;
    localparam int CW   = $clog2(MB + 1);
    localparam int BIAS = 2 ** (EB - 1) - 1;
    localparam int EMAX = 2 ** EB - 1;

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
    state_t r_state, w_next;

    logic                r_sign;
    logic signed [E-1:0] r_exp;
    logic [P-1:0]        r_mcand, r_prod;
    logic [MB:0]         r_mplier, r_sig;
    logic [CW-1:0]       r_cnt;
    logic                r_g, r_s;
    logic [W-1:0]        r_q;
    logic [4:0]          r_flags;

    logic [EB-1:0]       w_ea, w_eb;
    logic [MB-1:0]       w_fa, w_fb;
    logic                w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic                w_any_nan, w_inf_zero, w_special, w_sign;
    logic [W-1:0]        w_qnan, w_spec_q, w_rnd_q;
    logic [4:0]          w_spec_f, w_rnd_f;
    logic [P-1:0]        w_mcand, w_norm;
    logic [MB:0]         w_mplier, w_sig_r;
    logic                w_inc, w_carry, w_of, w_uf;
    logic signed [E-1:0] w_exp_r;

    assign w_ea       = bus.a[W-2:MB];
    assign w_eb       = bus.b[W-2:MB];
    assign w_fa       = bus.a[MB-1:0];
    assign w_fb       = bus.b[MB-1:0];
    assign w_a_zero   = w_ea == '0;
    assign w_b_zero   = w_eb == '0;
    assign w_a_inf    = (&w_ea) && !(|w_fa);
    assign w_b_inf    = (&w_eb) && !(|w_fb);
    assign w_a_nan    = (&w_ea) && (|w_fa);
    assign w_b_nan    = (&w_eb) && (|w_fb);
    assign w_a_snan   = w_a_nan && !w_fa[MB-1];
    assign w_b_snan   = w_b_nan && !w_fb[MB-1];
    assign w_any_nan  = w_a_nan | w_b_nan;
    assign w_inf_zero = (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_special  = w_any_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    assign w_sign     = bus.a[W-1] ^ bus.b[W-1];
    assign w_qnan     = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
    assign w_spec_q   = (w_any_nan | w_inf_zero) ? w_qnan :
                        (w_a_inf | w_b_inf)      ? {w_sign, {EB{1'b1}}, {MB{1'b0}}} :
                                                   {w_sign, {(W-1){1'b0}}};
    assign w_spec_f   = {(w_any_nan ? (w_a_snan | w_b_snan) : w_inf_zero), 4'b0000};

    // the accept edge already performs partial product 0, so MUL only walks bits 1..MB
    assign w_mcand    = P'({1'b1, w_fa});
    assign w_mplier   = {1'b1, w_fb};

    // product is in [1,4): bring the leading one to the MSB before slicing
    assign w_norm     = r_prod[P-1] ? r_prod : r_prod << 1;

    assign w_inc      = r_g & (r_s | r_sig[0]);
    assign {w_carry, w_sig_r} = {1'b0, r_sig} + (MB + 2)'(w_inc);
    assign w_exp_r    = r_exp + E'(w_carry);
    assign w_of       = int'(w_exp_r) >= EMAX;
    assign w_uf       = int'(w_exp_r) <= 0;
    assign w_rnd_q    = w_of ? {r_sign, {EB{1'b1}}, {MB{1'b0}}} :
                        w_uf ? {r_sign, {(W-1){1'b0}}} :
                               {r_sign, w_exp_r[EB-1:0], w_sig_r[MB-1:0]};
    assign w_rnd_f    = {2'b00, w_uf, w_of, w_of | w_uf | r_g | r_s};

    assign bus.in_ready  = r_state == IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.q         = r_q;
    assign bus.flags     = r_flags;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_valid ? (w_special ? DONE : MUL) : IDLE;
            MUL:     w_next = (r_cnt == '0) ? NORM : MUL;
            NORM:    w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_sig    <= '0;
            r_cnt    <= '0;
            r_g      <= 1'b0;
            r_s      <= 1'b0;
            r_q      <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_sign   <= w_sign;
                    r_exp    <= E'(w_ea) + E'(w_eb) - E'(BIAS);
                    r_prod   <= w_fb[0] ? w_mcand : '0;
                    r_mcand  <= w_mcand << 1;
                    r_mplier <= w_mplier >> 1;
                    r_cnt    <= CW'(MB - 1);
                    if (w_special) begin
                        r_q     <= w_spec_q;
                        r_flags <= w_spec_f;
                    end
                end
                MUL: begin
                    r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                end
                NORM: begin
                    r_exp <= r_exp + E'(r_prod[P-1]);
                    r_sig <= w_norm[P-1 -: MB+1];
                    r_g   <= w_norm[MB];
                    r_s   <= |w_norm[MB-1:0];
                end
                ROUND: begin
                    r_q     <= w_rnd_q;
                    r_flags <= w_rnd_f;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: randomized and directed checks of fp_mul_seq (half and single) against a value-level model
module tb_fp_mul_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fp_mul_seq_if #(.EB(5), .MB(10)) hb ();
    fp_mul_seq_if #(.EB(8), .MB(23)) sb ();

    fp_mul_seq #(.EB(5), .MB(10)) u_half   (.i_clk(clk), .i_rst_n(rst_n), .bus(hb));
    fp_mul_seq #(.EB(8), .MB(23)) u_single (.i_clk(clk), .i_rst_n(rst_n), .bus(sb));

    // exact product of the two significands, rounded to nearest-even by comparing the
    // discarded remainder against one half ulp
    function automatic logic [36:0] ref_mul(input int eb, input int mb, input logic [31:0] a, input logic [31:0] b);
        longint one   = 1;
        longint emax  = (one << eb) - 1;
        longint bias  = (one << (eb - 1)) - 1;
        longint fmask = (one << mb) - 1;
        longint xa    = (longint'(a) >> mb) & emax;
        longint xb    = (longint'(b) >> mb) & emax;
        longint fa    = longint'(a) & fmask;
        longint fb    = longint'(b) & fmask;
        longint sg    = ((longint'(a) ^ longint'(b)) >> (eb + mb)) & 1;
        longint zero  = sg << (eb + mb);
        longint inf   = zero | (emax << mb);
        longint qnan  = (emax << mb) | (one << (mb - 1));
        bit     an    = (xa == emax) && (fa != 0);
        bit     bn    = (xb == emax) && (fb != 0);
        bit     ai    = (xa == emax) && (fa == 0);
        bit     bi    = (xb == emax) && (fb == 0);
        bit     az    = xa == 0;
        bit     bz    = xb == 0;
        bit     asn   = an && (((fa >> (mb - 1)) & 1) == 0);
        bit     bsn   = bn && (((fb >> (mb - 1)) & 1) == 0);
        longint p, e, sh, sig, rem, half;
        if (an || bn) return {(asn || bsn) ? 5'b10000 : 5'b00000, qnan[31:0]};
        if ((ai && bz) || (bi && az)) return {5'b10000, qnan[31:0]};
        if (ai || bi) return {5'b00000, inf[31:0]};
        if (az || bz) return {5'b00000, zero[31:0]};
        p  = ((one << mb) | fa) * ((one << mb) | fb);
        e  = xa + xb - bias;
        sh = mb;
        if (p >= (one << (2 * mb + 1))) begin
            sh = mb + 1;
            e  = e + 1;
        end
        sig  = p >> sh;
        rem  = p & ((one << sh) - 1);
        half = one << (sh - 1);
        if (rem > half || (rem == half && sig[0])) sig = sig + 1;
        if (sig == (one << (mb + 1))) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= emax) return {5'b00011, inf[31:0]};
        if (e <= 0) return {5'b00101, zero[31:0]};
        sig = zero | (e << mb) | (sig & fmask);
        return {4'b0000, rem != 0, sig[31:0]};
    endfunction

    task automatic start(input bit sp, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (sp) begin
            sb.a = a; sb.b = b; sb.in_valid = 1'b1;
        end else begin
            hb.a = a[15:0]; hb.b = b[15:0]; hb.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (sp) sb.in_valid = 1'b0; else hb.in_valid = 1'b0;
    endtask

    // lat counts rising edges from the accept edge (inclusive) until out_valid is seen
    task automatic finish(input bit sp, input int pre, output logic [31:0] q, output logic [4:0] f, output int lat);
        lat = pre;
        while ((sp ? sb.out_valid : hb.out_valid) !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q = sp ? sb.q : {16'h0000, hb.q};
        f = sp ? sb.flags : hb.flags;
    endtask

    task automatic op(input bit sp, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] q, output logic [4:0] f, output int lat);
        start(sp, a, b);
        finish(sp, 1, q, f, lat);
        if ((sp ? sb.out_ready : hb.out_ready) === 1'b1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hb.in_valid = 1'b0; hb.out_ready = 1'b1; hb.a = '0; hb.b = '0;
        sb.in_valid = 1'b0; sb.out_ready = 1'b1; sb.a = '0; sb.b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({hb.in_ready, hb.out_valid, hb.q, hb.flags} !== {1'b1, 1'b0, 16'h0000, 5'h00}) begin
            n_err++;
            $display("FAIL reset_half got rdy=%b vld=%b q=%h f=%b exp rdy=1 vld=0 q=0000 f=00000",
                     hb.in_ready, hb.out_valid, hb.q, hb.flags);
        end
        n_cmp++;
        if ({sb.in_ready, sb.out_valid, sb.q, sb.flags} !== {1'b1, 1'b0, 32'h0, 5'h00}) begin
            n_err++;
            $display("FAIL reset_single got rdy=%b vld=%b q=%h f=%b exp rdy=1 vld=0 q=00000000 f=00000",
                     sb.in_ready, sb.out_valid, sb.q, sb.flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({hb.in_ready, hb.out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL post_reset_idle got rdy=%b vld=%b exp rdy=1 vld=0", hb.in_ready, hb.out_valid);
        end
    endtask

    task automatic test_directed_half();
        logic [15:0] ta [12] = '{16'h3C00, 16'h3E00, 16'hBC00, 16'h3C01, 16'h3C01, 16'h7BFF,
                                 16'h0400, 16'h8400, 16'h7C00, 16'h7D00, 16'h7E00, 16'hFC00};
        logic [15:0] tb [12] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h3C01, 16'h3BFF, 16'h7BFF,
                                 16'h0400, 16'h0400, 16'h0000, 16'h3C00, 16'h3C00, 16'h4000};
        logic [15:0] tq [12] = '{16'h3C00, 16'h4200, 16'hBC00, 16'h3C02, 16'h3C00, 16'h7C00,
                                 16'h0000, 16'h8000, 16'h7E00, 16'h7E00, 16'h7E00, 16'hFC00};
        logic [4:0]  tf [12] = '{5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00011,
                                 5'b00101, 5'b00101, 5'b10000, 5'b10000, 5'b00000, 5'b00000};
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            op(1'b0, {16'h0, ta[i]}, {16'h0, tb[i]}, q, f, lat);
            n_cmp++;
            if ({q[15:0], f} !== {tq[i], tf[i]}) begin
                n_err++;
                $display("FAIL directed_half[%0d] %h*%h got q=%h f=%b exp q=%h f=%b",
                         i, ta[i], tb[i], q[15:0], f, tq[i], tf[i]);
            end
            n_cmp++;
            if (lat !== (i < 8 ? 13 : 1)) begin
                n_err++;
                $display("FAIL latency_half[%0d] got %0d exp %0d", i, lat, (i < 8 ? 13 : 1));
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] ta [2] = '{32'h3F800000, 32'h7F7FFFFF};
        logic [31:0] tq [2] = '{32'h40000000, 32'h7F800000};
        logic [4:0]  tf [2] = '{5'b00000, 5'b00011};
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            op(1'b1, ta[i], 32'h40000000, q, f, lat);
            n_cmp++;
            if ({q, f} !== {tq[i], tf[i]}) begin
                n_err++;
                $display("FAIL directed_single[%0d] got q=%h f=%b exp q=%h f=%b", i, q, f, tq[i], tf[i]);
            end
            n_cmp++;
            if (lat !== 26) begin
                n_err++;
                $display("FAIL latency_single[%0d] got %0d exp 26", i, lat);
            end
        end
    endtask

    task automatic test_random(input bit sp, input int n);
        int          eb = sp ? 8 : 5;
        int          mb = sp ? 23 : 10;
        int          emax = (1 << eb) - 1;
        logic [31:0] a, b, q, fm;
        logic [4:0]  f;
        logic [36:0] r;
        int          lat, xa, xb, el;
        for (int i = 0; i < n; i++) begin
            fm = (32'h1 << mb) - 1;
            if (i % 5 == 4) begin
                xa = $urandom_range(0, emax);
                xb = $urandom_range(0, emax);
            end else begin
                xa = $urandom_range(1, emax - 1);
                xb = $urandom_range(1, emax - 1);
            end
            a  = ((32'($urandom_range(0, 1))) << (eb + mb)) | (32'(xa) << mb) | ($urandom & fm);
            b  = ((32'($urandom_range(0, 1))) << (eb + mb)) | (32'(xb) << mb) | ($urandom & fm);
            r  = ref_mul(eb, mb, a, b);
            el = (xa == 0 || xb == 0 || xa == emax || xb == emax) ? 1 : mb + 3;
            op(sp, a, b, q, f, lat);
            n_cmp++;
            if ({f, q} !== r) begin
                n_err++;
                $display("FAIL random_%s[%0d] %h*%h got q=%h f=%b exp q=%h f=%b",
                         sp ? "single" : "half", i, a, b, q, f, r[31:0], r[36:32]);
            end
            n_cmp++;
            if (lat !== el) begin
                n_err++;
                $display("FAIL random_latency_%s[%0d] got %0d exp %0d", sp ? "single" : "half", i, lat, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, q;
        logic [4:0]  f;
        logic [36:0] r;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            a = {16'h0, 1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
            b = {16'h0, 1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
            r = ref_mul(5, 10, a, b);
            n_cmp++;
            if (hb.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d] got %b exp 1", i, hb.in_ready);
            end
            op(1'b0, a, b, q, f, lat);
            n_cmp++;
            if ({f, q} !== r || lat !== 13) begin
                n_err++;
                $display("FAIL b2b[%0d] got q=%h f=%b lat=%0d exp q=%h f=%b lat=13",
                         i, q[15:0], f, lat, r[15:0], r[36:32]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q;
        logic [4:0]  f;
        int          lat, bad;
        hb.out_ready = 1'b0;
        start(1'b0, 32'h3E00, 32'h4000);
        finish(1'b0, 1, q, f, lat);
        n_cmp++;
        if ({q[15:0], f} !== {16'h4200, 5'b00000} || lat !== 13) begin
            n_err++;
            $display("FAIL bp_result got q=%h f=%b lat=%0d exp q=4200 f=00000 lat=13", q[15:0], f, lat);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (hb.q !== 16'h4200 || hb.flags !== 5'b00000 || hb.out_valid !== 1'b1 || hb.in_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bp_hold got %0d unstable cycles exp 0", bad);
        end
        @(negedge clk);
        hb.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({hb.out_valid, hb.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", hb.out_valid, hb.in_ready);
        end
    endtask

    task automatic test_ignore_inputs();
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
        start(1'b0, 32'h3E00, 32'h4000);
        hb.in_valid = 1'b1;
        hb.a = 16'h7E00;
        hb.b = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (hb.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_ready[%0d] got %b exp 0", i, hb.in_ready);
            end
        end
        hb.in_valid = 1'b0;
        hb.a = 16'h5555;
        finish(1'b0, 4, q, f, lat);
        @(posedge clk);
        #1;
        n_cmp++;
        if ({q[15:0], f} !== {16'h4200, 5'b00000} || lat !== 13) begin
            n_err++;
            $display("FAIL ignore_result got q=%h f=%b lat=%0d exp q=4200 f=00000 lat=13", q[15:0], f, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        logic [4:0]  f;
        int          lat, seen;
        start(1'b0, 32'h3C00, 32'h3C00);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({hb.in_ready, hb.out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL midreset got rdy=%b vld=%b exp rdy=1 vld=0", hb.in_ready, hb.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (hb.out_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL midreset_no_output got %0d valid cycles exp 0", seen);
        end
        op(1'b0, 32'hC000, 32'h3E00, q, f, lat);
        n_cmp++;
        if ({q[15:0], f} !== {16'hC200, 5'b00000} || lat !== 13) begin
            n_err++;
            $display("FAIL after_reset got q=%h f=%b lat=%0d exp q=c200 f=00000 lat=13", q[15:0], f, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed_half();
        test_single();
        test_random(1'b0, 60);
        test_random(1'b1, 30);
        test_back_to_back();
        test_backpressure();
        test_ignore_inputs();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
